fetch_stage: RTL

- Instruction-fetch stage of the 5-stage ARM pipeline.
- Owns the fetch PC and drives the address of the synchronous code memory (1-cycle read latency).
- Registers the returned word into the decode-stage instruction register with a valid bit and the instruction's PC.
- Handles stall (hold), redirect from execute (branch/BL/PC write, flushing the younger instruction) and out-of-range fetch halt.

---
 rtl/fetch_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the code memory
// address and registers the returned word into the decode register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'hE1A0_0000,
  parameter int unsigned CODE_BYTES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] decd_inst,
  output logic [31:0] decd_pc,
  output logic [31:0] decd_pc_plus8,
  output logic        decd_valid,
  output logic [1:0]  fetch_state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [31:0] CODE_LIM = 32'(CODE_BYTES);

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] decd_inst_q, decd_inst_d;
  logic [31:0] decd_pc_q, decd_pc_d;
  logic        decd_valid_q, decd_valid_d;

  logic [31:0] tgt_pc;
  logic [31:0] pc_inc;
  logic        unused_lsb;

  assign tgt_pc     = {redirect_pc[31:2], 2'b00};
  assign pc_inc     = req_pc_q + 32'd4;
  assign unused_lsb = ^redirect_pc[1:0];

  always_comb begin
    if (redirect_en) begin
      imem_addr = tgt_pc;
    end else if (state_q == BOOT) begin
      imem_addr = RESET_PC;
    end else if (stall || state_q == HALT) begin
      imem_addr = req_pc_q;
    end else begin
      imem_addr = pc_inc;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    req_valid_d  = req_valid_q;
    decd_inst_d  = decd_inst_q;
    decd_pc_d    = decd_pc_q;
    decd_valid_d = decd_valid_q;
    if (redirect_en) begin
      // squash the younger word; target lands in decode two edges later
      req_pc_d     = tgt_pc;
      req_valid_d  = 1'b1;
      decd_inst_d  = NOP_INST;
      decd_valid_d = 1'b0;
      decd_pc_d    = tgt_pc;
      state_d      = (tgt_pc >= CODE_LIM) ? HALT : RUN;
    end else if (state_q == BOOT) begin
      req_pc_d    = RESET_PC;
      req_valid_d = 1'b1;
      state_d     = RUN;
    end else if (stall) begin
      state_d = state_q;
    end else if (state_q == HALT) begin
      decd_inst_d  = NOP_INST;
      decd_valid_d = 1'b0;
    end else begin
      decd_inst_d  = req_valid_q ? imem_data : NOP_INST;
      decd_valid_d = req_valid_q;
      decd_pc_d    = req_pc_q;
      req_pc_d     = pc_inc;
      req_valid_d  = 1'b1;
      if (pc_inc >= CODE_LIM) begin
        state_d     = HALT;
        req_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= BOOT;
      req_pc_q     <= RESET_PC;
      req_valid_q  <= 1'b0;
      decd_inst_q  <= NOP_INST;
      decd_pc_q    <= 32'd0;
      decd_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      req_valid_q  <= req_valid_d;
      decd_inst_q  <= decd_inst_d;
      decd_pc_q    <= decd_pc_d;
      decd_valid_q <= decd_valid_d;
    end
  end

  assign decd_inst     = decd_inst_q;
  assign decd_pc       = decd_pc_q;
  assign decd_pc_plus8 = decd_pc_q + 32'd8;
  assign decd_valid    = decd_valid_q;
  assign fetch_state   = state_q;

endmodule
